// File: rtl/mem_pkg.sv
// Shared constants for the data-memory access path: Funct3 access sizes and controller states.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} MemState;

endpackage

// File: rtl/mem_access_unit_store_aligner.sv
// Builds lane-replicated store data and byte enables from size and byte offset, and flags misaligned sizes.
module store_aligner
  import mem_pkg::*;
(
  input  logic [2:0]  Funct3M,
  input  logic [1:0]  byteOffset,
  input  logic [31:0] StoreDataM,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        misalign
);

  // Unlisted encodings fall through to word behaviour.
  always_comb begin
    wdata    = StoreDataM;
    be       = 4'b1111;
    misalign = 1'b0;
    case (Funct3M)
      F3_B, F3_BU: begin
        wdata = {4{StoreDataM[7:0]}};
        be    = 4'b0001 << byteOffset;
      end
      F3_H, F3_HU: begin
        wdata    = {2{StoreDataM[15:0]}};
        be       = byteOffset[1] ? 4'b1100 : 4'b0011;
        misalign = byteOffset[0];
      end
      default: misalign = |byteOffset;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store controller: IDLE -> BUSY (req until ready) -> DONE, stalling the pipeline meanwhile.
// Optional MEM_TIMEOUT_EN aborts a BUSY access after TIMEOUT_CYCLES cycles without mem_ready and pulses FaultM.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [2:0]        Funct3M,
  input  logic [ADDR_W-1:0] ALUOutM,
  input  logic [31:0]       StoreDataM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       DataMemOutM,
  output logic              StallM,
  output logic              MisalignM,
  output logic              FaultM
);

  MemState     state, nextState;
  logic        access, misalign, startAccess, timeoutHit;
  logic [31:0] alignedWdata;
  logic [3:0]  alignedBe;
  logic [1:0]  offsetReg;

  store_aligner uAligner (
    .Funct3M    (Funct3M),
    .byteOffset (ALUOutM[1:0]),
    .StoreDataM (StoreDataM),
    .wdata      (alignedWdata),
    .be         (alignedBe),
    .misalign   (misalign)
  );

  assign access      = MemReadM | MemWriteM;
  assign startAccess = !reset && (state == IDLE) && access && !misalign;
  assign mem_req     = (state == BUSY);
  assign StallM      = startAccess || (state == BUSY);
  assign MisalignM   = !reset && (state == IDLE) && access && misalign;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] waitCnt;
  logic             faultReg;

  assign timeoutHit = (state == BUSY) && !mem_ready && (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign FaultM     = faultReg;

  // Counts BUSY cycles without a response; FaultM is high during the DONE cycle that follows an abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waitCnt  <= '0;
      faultReg <= 1'b0;
    end else begin
      faultReg <= timeoutHit;
      if (startAccess)
        waitCnt <= '0;
      else if (state == BUSY && !mem_ready)
        waitCnt <= waitCnt + 1'b1;
    end
  end
`else
  assign timeoutHit = 1'b0;
  assign FaultM     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // DONE is a mandatory one-cycle gap so the still-present instruction is not issued twice.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (startAccess) nextState = BUSY;
      BUSY:    if (mem_ready || timeoutHit) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Request fields are frozen on issue so they stay stable while the memory holds off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_be      <= 4'b0000;
      mem_wdata   <= '0;
      offsetReg   <= 2'b00;
      DataMemOutM <= '0;
    end else begin
      if (startAccess) begin
        mem_addr  <= {ALUOutM[ADDR_W-1:2], 2'b00};
        mem_we    <= MemWriteM;
        mem_be    <= MemWriteM ? alignedBe : 4'b1111;
        mem_wdata <= alignedWdata;
        offsetReg <= ALUOutM[1:0];
      end
      if (state == BUSY && mem_ready && !mem_we)
        DataMemOutM <= mem_rdata >> {offsetReg, 3'b000};
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected requests/results are queued when stimulus is driven.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUOutM, StoreDataM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata, DataMemOutM;
  logic        StallM, MisalignM, FaultM;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          reqCycles;
    int          stallCycles;
    logic [31:0] dataOut;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          reqCycles;
    int          stallCycles;
    bit          stable;
    bit          misalign;
    bit          misalignAfter;
    bit          doneStall;
    bit          fault;
    bit          finished;
    logic [31:0] dataOut;
  } obs_t;

  exp_t expQ[$];

  mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .Funct3M(Funct3M), .ALUOutM(ALUOutM), .StoreDataM(StoreDataM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .DataMemOutM(DataMemOutM), .StallM(StallM), .MisalignM(MisalignM), .FaultM(FaultM)
  );

  always #5 clk = ~clk;

  // Drives one access from IDLE and plays memory, answering after readyDelay un-ready BUSY cycles.
  task automatic doAccess(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] data,
                          input int readyDelay, input logic [31:0] rdata, output obs_t obs);
    int busy;
    obs.addr = '0; obs.we = 0; obs.be = '0; obs.wdata = '0;
    obs.reqCycles = 0; obs.stallCycles = 0; obs.stable = 1; obs.misalign = 0;
    obs.misalignAfter = 0; obs.doneStall = 0; obs.fault = 0; obs.finished = 0; obs.dataOut = '0;
    MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUOutM = addr; StoreDataM = data;
    mem_rdata = rdata; mem_ready = 0;
    #1;
    obs.misalign = MisalignM;
    if (StallM) obs.stallCycles++;
    busy = 0;
    if (!StallM) begin
      @(negedge clk);
      if (mem_req) obs.reqCycles++;
      obs.finished = 1;
    end else begin
      for (int c = 0; c < 64 && !obs.finished; c++) begin
        @(negedge clk);
        if (mem_req) begin
          if (busy == 0) begin
            obs.addr = mem_addr; obs.we = mem_we; obs.be = mem_be; obs.wdata = mem_wdata;
          end else if (mem_addr !== obs.addr || mem_we !== obs.we || mem_be !== obs.be || mem_wdata !== obs.wdata) begin
            obs.stable = 0;
          end
          obs.reqCycles++;
          if (StallM) obs.stallCycles++;
          mem_ready = (busy == readyDelay);
          busy++;
        end else begin
          mem_ready = 0;
          obs.doneStall = StallM;
          obs.fault = FaultM;
          obs.dataOut = DataMemOutM;
          obs.finished = 1;
        end
      end
    end
    MemReadM = 0; MemWriteM = 0; mem_ready = 0;
    @(negedge clk);
    obs.misalignAfter = MisalignM;
  endtask

  task automatic test_reset();
    reset = 1; MemReadM = 0; MemWriteM = 0; Funct3M = F3_W; ALUOutM = '0;
    StoreDataM = '0; mem_ready = 0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_be, StallM, MisalignM, FaultM} !== 9'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl got req=%b we=%b be=%b stall=%b mis=%b fault=%b expected all 0",
               mem_req, mem_we, mem_be, StallM, MisalignM, FaultM);
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || DataMemOutM !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_data got addr=%h wdata=%h dout=%h expected 0", mem_addr, mem_wdata, DataMemOutM);
    end
    reset = 0;
    @(negedge clk);
  endtask

  // Compares one completed access against the head of the scoreboard.
  task automatic test_store_word();
    obs_t o; exp_t e;
    expQ.push_back('{32'h100, 1'b1, 4'b1111, 32'hDEADBEEF, 1, 2, 32'h0});
    doAccess(1'b0, 1'b1, F3_W, 32'h100, 32'hDEADBEEF, 0, 32'h0, o);
    e = expQ.pop_front();
    checks++;
    if (o.addr !== e.addr || o.we !== e.we || o.be !== e.be || o.wdata !== e.wdata) begin
      failures++;
      $display("[TB] FAIL sw_fields got addr=%h we=%b be=%b wdata=%h expected addr=%h we=%b be=%b wdata=%h",
               o.addr, o.we, o.be, o.wdata, e.addr, e.we, e.be, e.wdata);
    end
    checks++;
    if (o.reqCycles != e.reqCycles || o.stallCycles != e.stallCycles || o.doneStall !== 1'b0 || !o.finished) begin
      failures++;
      $display("[TB] FAIL sw_timing got req=%0d stall=%0d doneStall=%b fin=%b expected req=%0d stall=%0d doneStall=0 fin=1",
               o.reqCycles, o.stallCycles, o.doneStall, o.finished, e.reqCycles, e.stallCycles);
    end
  endtask

  task automatic test_loads();
    obs_t o; exp_t e;
    logic [2:0]  f3[4]  = '{F3_H, F3_BU, F3_B, F3_W};
    logic [31:0] ad[4]  = '{32'h302, 32'h503, 32'h501, 32'h504};
    logic [31:0] rd[4]  = '{32'h80017FFF, 32'h11223344, 32'h11223344, 32'hA1B2C3D4};
    logic [31:0] res[4] = '{32'h00008001, 32'h00000011, 32'h00112233, 32'hA1B2C3D4};
    int          dly[4] = '{3, 0, 1, 2};
    for (int i = 0; i < 4; i++) begin
      expQ.push_back('{ad[i] & 32'hFFFFFFFC, 1'b0, 4'b1111, 32'h0, dly[i] + 1, dly[i] + 2, res[i]});
      doAccess(1'b1, 1'b0, f3[i], ad[i], 32'h0, dly[i], rd[i], o);
      e = expQ.pop_front();
      checks++;
      if (o.addr !== e.addr || o.we !== e.we || o.be !== e.be || o.dataOut !== e.dataOut) begin
        failures++;
        $display("[TB] FAIL load%0d got addr=%h we=%b be=%b dout=%h expected addr=%h we=%b be=%b dout=%h",
                 i, o.addr, o.we, o.be, o.dataOut, e.addr, e.we, e.be, e.dataOut);
      end
      checks++;
      if (o.reqCycles != e.reqCycles || o.stallCycles != e.stallCycles || !o.stable || o.doneStall !== 1'b0) begin
        failures++;
        $display("[TB] FAIL load%0d_timing got req=%0d stall=%0d stable=%b doneStall=%b expected req=%0d stall=%0d stable=1 doneStall=0",
                 i, o.reqCycles, o.stallCycles, o.stable, o.doneStall, e.reqCycles, e.stallCycles);
      end
    end
  endtask

  // Stores must leave the last loaded word (0xA1B2C3D4) untouched.
  task automatic test_stores();
    obs_t o; exp_t e;
    logic        rdq[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3[6]  = '{F3_B, F3_B, F3_H, F3_H, 3'b011, F3_W};
    logic [31:0] ad[6]  = '{32'h203, 32'h201, 32'h602, 32'h600, 32'h700, 32'h704};
    logic [31:0] sd[6]  = '{32'h000000A5, 32'h12345677, 32'h1234ABCD, 32'h1234ABCD, 32'hCAFEF00D, 32'h0BADF00D};
    logic [31:0] wd[6]  = '{32'hA5A5A5A5, 32'h77777777, 32'hABCDABCD, 32'hABCDABCD, 32'hCAFEF00D, 32'h0BADF00D};
    logic [3:0]  bes[6] = '{4'b1000, 4'b0010, 4'b1100, 4'b0011, 4'b1111, 4'b1111};
    for (int i = 0; i < 6; i++) begin
      expQ.push_back('{ad[i] & 32'hFFFFFFFC, 1'b1, bes[i], wd[i], 2, 3, 32'hA1B2C3D4});
      doAccess(rdq[i], 1'b1, f3[i], ad[i], sd[i], 1, 32'hFFFFFFFF, o);
      e = expQ.pop_front();
      checks++;
      if (o.addr !== e.addr || o.we !== e.we || o.be !== e.be || o.wdata !== e.wdata || o.dataOut !== e.dataOut) begin
        failures++;
        $display("[TB] FAIL store%0d got addr=%h we=%b be=%b wdata=%h dout=%h expected addr=%h we=%b be=%b wdata=%h dout=%h",
                 i, o.addr, o.we, o.be, o.wdata, o.dataOut, e.addr, e.we, e.be, e.wdata, e.dataOut);
      end
      checks++;
      if (o.reqCycles != e.reqCycles || o.stallCycles != e.stallCycles || !o.stable) begin
        failures++;
        $display("[TB] FAIL store%0d_timing got req=%0d stall=%0d stable=%b expected req=%0d stall=%0d stable=1",
                 i, o.reqCycles, o.stallCycles, o.stable, e.reqCycles, e.stallCycles);
      end
    end
  endtask

  task automatic test_misalign();
    obs_t o;
    logic        rdq[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0]  f3[4]  = '{F3_W, F3_H, F3_HU, F3_W};
    logic [31:0] ad[4]  = '{32'h101, 32'h303, 32'h105, 32'h102};
    for (int i = 0; i < 4; i++) begin
      doAccess(rdq[i], !rdq[i], f3[i], ad[i], 32'h55555555, 0, 32'h0, o);
      checks++;
      if (o.misalign !== 1'b1 || o.stallCycles != 0 || o.reqCycles != 0 || o.misalignAfter !== 1'b0) begin
        failures++;
        $display("[TB] FAIL misalign%0d got mis=%b stall=%0d req=%0d misAfter=%b expected mis=1 stall=0 req=0 misAfter=0",
                 i, o.misalign, o.stallCycles, o.reqCycles, o.misalignAfter);
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    MemReadM = 1; MemWriteM = 0; Funct3M = F3_W; ALUOutM = 32'h400; mem_ready = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("[TB] FAIL busy_before_reset got req=%b expected 1", mem_req);
    end
    reset = 1;
    #1;
    checks++;
    if ({mem_req, mem_we, mem_be, StallM, MisalignM, FaultM} !== 9'b0 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0 || DataMemOutM !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_mid_busy got req=%b we=%b be=%b stall=%b addr=%h wdata=%h dout=%h expected all 0",
               mem_req, mem_we, mem_be, StallM, mem_addr, mem_wdata, DataMemOutM);
    end
    MemReadM = 0;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || StallM !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_after_reset got req=%b stall=%b expected 0 0", mem_req, StallM);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
`ifdef MEM_TIMEOUT_EN
    doAccess(1'b1, 1'b0, F3_W, 32'h900, 32'h0, 0, 32'h12345678, o);
    doAccess(1'b1, 1'b0, F3_W, 32'h904, 32'h0, 1000, 32'hFFFFFFFF, o);
    checks++;
    if (o.reqCycles != 4 || o.fault !== 1'b1 || o.dataOut !== 32'h12345678 || !o.finished) begin
      failures++;
      $display("[TB] FAIL timeout got req=%0d fault=%b dout=%h fin=%b expected req=4 fault=1 dout=12345678 fin=1",
               o.reqCycles, o.fault, o.dataOut, o.finished);
    end
    checks++;
    if (FaultM !== 1'b0 || StallM !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timeout_idle got fault=%b stall=%b req=%b expected 0 0 0", FaultM, StallM, mem_req);
    end
`else
    bit dropped;
    dropped = 0;
    doAccess(1'b1, 1'b0, F3_W, 32'h900, 32'h0, 0, 32'h12345678, o);
    MemReadM = 1; Funct3M = F3_W; ALUOutM = 32'h904; mem_ready = 0;
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem_req !== 1'b1 || FaultM !== 1'b0) dropped = 1;
    end
    checks++;
    if (dropped || DataMemOutM !== 32'h12345678) begin
      failures++;
      $display("[TB] FAIL no_timeout got dropped=%b dout=%h expected dropped=0 dout=12345678", dropped, DataMemOutM);
    end
    MemReadM = 0; reset = 1;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
`endif
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_loads();
    test_stores();
    test_misalign();
    test_reset_mid_busy();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
